// File: rtl/cpu_pkg.sv
// Shared CPU-side types for the memory responder and its RAM.
// Exports word_t, mem_resp_state_t and WORD_BYTES.
package cpu_pkg;

  typedef logic [15:0] word_t;

  typedef enum logic [1:0] {
    IDLE,
    RD_WAIT,
    RESP
  } mem_resp_state_t;

  localparam int WORD_BYTES = 2;

endpackage

// File: rtl/mem_resp_ram.sv
// Single-port synchronous RAM, DEPTH x 16, read-first.
// Ports: clk, i_we, i_addr (word index), i_din, o_dout (registered).
module mem_resp_ram
  import cpu_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_addr,
  input  word_t         i_din,
  output word_t         o_dout
);

  word_t r_mem [DEPTH];
  word_t r_dout;

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_din;
    end
    r_dout <= r_mem[i_addr];
  end

  assign o_dout = r_dout;

endmodule

// File: rtl/mem_responder.sv
// Memory-side target: 16-bit word RAM, byte addressing, read latency,
// waitrequest stall, error pulse on misaligned/out-of-range accesses.
// Ports: clk, reset (sync, high), i_mem_addr/rd/wr/wrdata,
//   o_mem_rddata/_valid, o_mem_waitrequest, o_err, i_switches, o_leds.
// Optional MMIO window (o_leds / i_switches): define MEM_RESP_MMIO_EN.
module mem_responder
  import cpu_pkg::*;
#(
  parameter int          DEPTH_WORDS = 256,
  parameter int          RD_LATENCY  = 2,
  parameter logic [15:0] MMIO_BASE   = 16'hFF00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] i_mem_addr,
  input  logic        i_mem_rd,
  input  logic        i_mem_wr,
  input  logic [15:0] i_mem_wrdata,
  output logic [15:0] o_mem_rddata,
  output logic        o_mem_rddata_valid,
  output logic        o_mem_waitrequest,
  output logic        o_err,
  input  logic [15:0] i_switches,
  output logic [15:0] o_leds
);

  localparam int AW = $clog2(DEPTH_WORDS);

  localparam logic [1:0] CNT_INIT =
    (RD_LATENCY > 1) ? 2'(RD_LATENCY - 2) : 2'd0;

  localparam logic [15:0] DEPTH_L = 16'(DEPTH_WORDS);

  typedef enum logic [1:0] {
    SRC_RAM,
    SRC_REG,
    SRC_OOR
  } src_t;

  mem_resp_state_t r_state;
  mem_resp_state_t w_next;

  logic [1:0]    r_cnt;
  logic [AW-1:0] r_idx;
  src_t          r_src;
  word_t         r_mmio_q;
  word_t         r_leds;
  logic          r_err;

  word_t         w_ram_dout;
  logic [AW-1:0] w_ram_idx;
  logic          w_ram_we;

  logic w_idle;
  logic w_wr_acc;
  logic w_rd_acc;
  logic w_misal;
  logic w_ram_hit;
  logic w_mmio;
  logic w_led_hit;
  logic w_sw_hit;
  logic w_in_ram;
  logic w_oor;
  logic w_err_nxt;

  // Address decode
  assign w_misal   = i_mem_addr[0];
  assign w_ram_hit = {1'b0, i_mem_addr[15:1]} < DEPTH_L;

`ifdef MEM_RESP_MMIO_EN
  localparam logic [15:0] SW_ADDR =
    MMIO_BASE + 16'(WORD_BYTES);

  assign w_mmio    = i_mem_addr >= MMIO_BASE;
  assign w_led_hit = w_mmio &&
    (i_mem_addr[15:1] == MMIO_BASE[15:1]);
  assign w_sw_hit  = w_mmio &&
    (i_mem_addr[15:1] == SW_ADDR[15:1]);
`else
  logic w_unused_sw;
  assign w_unused_sw = ^i_switches;
  assign w_mmio      = 1'b0;
  assign w_led_hit   = 1'b0;
  assign w_sw_hit    = 1'b0;
`endif

  assign w_in_ram = w_ram_hit && !w_mmio;
  assign w_oor    = !w_in_ram && !w_led_hit && !w_sw_hit;

  // Handshake
  assign w_idle   = (r_state == IDLE);
  assign w_wr_acc = w_idle && i_mem_wr;
  assign w_rd_acc = w_idle && i_mem_rd && !i_mem_wr;

  // Out-of-range reads flag alongside valid instead.
  assign w_err_nxt = w_idle && (i_mem_rd || i_mem_wr) &&
    (w_misal || (i_mem_rd && i_mem_wr) || (i_mem_wr && w_oor));

  // RAM port: live address when idle so a latency-1 read
  // has data in RESP; latched index while a read is pending.
  assign w_ram_we  = w_wr_acc && w_in_ram;
  assign w_ram_idx = w_idle ? i_mem_addr[AW:1] : r_idx;

  mem_resp_ram #(
    .DEPTH (DEPTH_WORDS),
    .AW    (AW)
  ) u_ram (
    .clk    (clk),
    .i_we   (w_ram_we),
    .i_addr (w_ram_idx),
    .i_din  (i_mem_wrdata),
    .o_dout (w_ram_dout)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Request bookkeeping
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt    <= 2'd0;
      r_idx    <= '0;
      r_src    <= SRC_RAM;
      r_mmio_q <= '0;
      r_leds   <= '0;
      r_err    <= 1'b0;
    end else begin
      r_err <= w_err_nxt;
      if (r_state == RD_WAIT) begin
        r_cnt <= r_cnt - 2'd1;
      end
      if (w_rd_acc) begin
        r_cnt <= CNT_INIT;
        r_idx <= i_mem_addr[AW:1];
        unique case (1'b1)
          w_in_ram:              r_src <= SRC_RAM;
          (w_led_hit | w_sw_hit): r_src <= SRC_REG;
          default:               r_src <= SRC_OOR;
        endcase
`ifdef MEM_RESP_MMIO_EN
        r_mmio_q <= w_led_hit ? r_leds : i_switches;
`endif
      end
`ifdef MEM_RESP_MMIO_EN
      if (w_wr_acc && w_led_hit) begin
        r_leds <= i_mem_wrdata;
      end
`endif
    end
  end

  // Next state
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_rd_acc) begin
          w_next = (RD_LATENCY == 1) ? RESP : RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (r_cnt == 2'd0) begin
          w_next = RESP;
        end
      end
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    o_mem_waitrequest  = 1'b0;
    o_mem_rddata_valid = 1'b0;
    o_mem_rddata       = '0;
    o_err              = r_err;
    unique case (r_state)
      IDLE: ;
      RD_WAIT: o_mem_waitrequest = 1'b1;
      RESP: begin
        o_mem_waitrequest  = 1'b1;
        o_mem_rddata_valid = 1'b1;
        unique case (r_src)
          SRC_RAM: o_mem_rddata = w_ram_dout;
          SRC_REG: o_mem_rddata = r_mmio_q;
          default: o_err        = 1'b1;
        endcase
      end
      default: ;
    endcase
  end

  assign o_leds = r_leds;

endmodule

// File: tb/tb_mem_responder.sv
// Randomized self-checking bench for mem_responder.
// Reference model: word array indexed by byte address / 2.
module tb_mem_responder;
  import cpu_pkg::*;

  localparam int DEPTH = 256;
  localparam int L     = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] i_mem_addr = '0;
  logic        i_mem_rd = 1'b0;
  logic        i_mem_wr = 1'b0;
  logic [15:0] i_mem_wrdata = '0;
  logic [15:0] o_mem_rddata;
  logic        o_mem_rddata_valid;
  logic        o_mem_waitrequest;
  logic        o_err;
  logic [15:0] i_switches = '0;
  logic [15:0] o_leds;

  int checks = 0;
  int errors = 0;

  word_t mdl [DEPTH];
  bit    written [DEPTH];

  mem_responder #(
    .DEPTH_WORDS (DEPTH),
    .RD_LATENCY  (L),
    .MMIO_BASE   (16'hFF00)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .i_mem_addr         (i_mem_addr),
    .i_mem_rd           (i_mem_rd),
    .i_mem_wr           (i_mem_wr),
    .i_mem_wrdata       (i_mem_wrdata),
    .o_mem_rddata       (o_mem_rddata),
    .o_mem_rddata_valid (o_mem_rddata_valid),
    .o_mem_waitrequest  (o_mem_waitrequest),
    .o_err              (o_err),
    .i_switches         (i_switches),
    .o_leds             (o_leds)
  );

  always #5 clk = ~clk;

  function automatic void model_write(input logic [15:0] a,
                                      input word_t d);
    int idx;
    idx = int'(a >> 1);
    if (idx < DEPTH) begin
      mdl[idx] = d;
      written[idx] = 1'b1;
    end
  endfunction

  task automatic wait_idle(input string who);
    int n;
    n = 0;
    @(negedge clk);
    while (o_mem_waitrequest && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (o_mem_waitrequest) begin
      errors++;
      $display("FAIL %s_timeout waitrequest stuck high", who);
    end
  endtask

  task automatic do_write(input logic [15:0] a, input word_t d,
                          output bit e);
    @(posedge clk); #1;
    i_mem_addr = a;
    i_mem_wrdata = d;
    i_mem_wr = 1'b1;
    wait_idle("write");
    @(posedge clk); #1;
    i_mem_wr = 1'b0;
    @(negedge clk);
    e = o_err;
    model_write(a, d);
  endtask

  // Collects what the DUT did over the window after acceptance.
  task automatic observe(output word_t d, output int wcnt,
                         output int vcnt, output int vidx,
                         output int ecnt, output int eidx);
    d = '0; wcnt = 0; vcnt = 0; vidx = -1; ecnt = 0; eidx = -1;
    for (int k = 0; k < L + 2; k++) begin
      @(negedge clk);
      if (o_mem_waitrequest) wcnt++;
      if (o_mem_rddata_valid) begin
        vcnt++;
        d = o_mem_rddata;
        if (vidx < 0) vidx = k;
      end
      if (o_err) begin
        ecnt++;
        if (eidx < 0) eidx = k;
      end
    end
  endtask

  task automatic do_read(input logic [15:0] a, output word_t d,
                         output int wcnt, output int vcnt,
                         output int vidx, output int ecnt,
                         output int eidx);
    @(posedge clk); #1;
    i_mem_addr = a;
    i_mem_rd = 1'b1;
    wait_idle("read");
    @(posedge clk); #1;
    i_mem_rd = 1'b0;
    observe(d, wcnt, vcnt, vidx, ecnt, eidx);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (o_mem_waitrequest !== 1'b0 || o_mem_rddata_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_hs got wr=%b v=%b exp 0 0",
               o_mem_waitrequest, o_mem_rddata_valid);
    end
    #1 reset = 1'b0;
    @(negedge clk);
    checks++;
    if (o_mem_rddata !== 16'h0) begin
      errors++;
      $display("FAIL reset_rddata got %h exp 0000", o_mem_rddata);
    end
    checks++;
    if (o_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_err got %b exp 0", o_err);
    end
    checks++;
    if (o_leds !== 16'h0) begin
      errors++;
      $display("FAIL reset_leds got %h exp 0000", o_leds);
    end
  endtask

  task automatic test_basic;
    bit e;
    word_t d;
    int wc, vc, vi, ec, ei;
    do_write(16'h0010, 16'h1234, e);
    checks++;
    if (e !== 1'b0) begin
      errors++;
      $display("FAIL basic_wr_err got %b exp 0", e);
    end
    do_read(16'h0010, d, wc, vc, vi, ec, ei);
    checks++;
    if (wc != L) begin
      errors++;
      $display("FAIL basic_wait got %0d exp %0d", wc, L);
    end
    checks++;
    if (vc != 1 || vi != L - 1) begin
      errors++;
      $display("FAIL basic_valid got n=%0d at %0d exp 1 at %0d",
               vc, vi, L - 1);
    end
    checks++;
    if (d !== 16'h1234) begin
      errors++;
      $display("FAIL basic_data got %h exp 1234", d);
    end
    checks++;
    if (ec != 0) begin
      errors++;
      $display("FAIL basic_err got %0d exp 0", ec);
    end
  endtask

  task automatic test_misaligned;
    bit e;
    word_t d;
    int wc, vc, vi, ec, ei;
    do_write(16'h0010, 16'hBEEF, e);
    do_read(16'h0011, d, wc, vc, vi, ec, ei);
    checks++;
    if (d !== 16'hBEEF || vc != 1) begin
      errors++;
      $display("FAIL misal_data got %h n=%0d exp beef n=1", d, vc);
    end
    checks++;
    if (ec != 1 || ei != 0) begin
      errors++;
      $display("FAIL misal_err got n=%0d at %0d exp 1 at 0", ec, ei);
    end
    do_write(16'h0021, 16'hC0DE, e);
    checks++;
    if (e !== 1'b1) begin
      errors++;
      $display("FAIL misal_wr_err got %b exp 1", e);
    end
    do_read(16'h0020, d, wc, vc, vi, ec, ei);
    checks++;
    if (d !== 16'hC0DE || ec != 0) begin
      errors++;
      $display("FAIL misal_wr_data got %h e=%0d exp c0de e=0", d, ec);
    end
  endtask

  task automatic test_out_of_range;
    bit e;
    word_t d;
    int wc, vc, vi, ec, ei;
    do_write(16'h0000, 16'h1111, e);
    do_write(16'h0200, 16'hAAAA, e);
    checks++;
    if (e !== 1'b1) begin
      errors++;
      $display("FAIL oor_wr_err got %b exp 1", e);
    end
    do_read(16'h0000, d, wc, vc, vi, ec, ei);
    checks++;
    if (d !== 16'h1111) begin
      errors++;
      $display("FAIL oor_word0 got %h exp 1111", d);
    end
    do_read(16'h0200, d, wc, vc, vi, ec, ei);
    checks++;
    if (d !== 16'h0000 || vc != 1) begin
      errors++;
      $display("FAIL oor_rd_data got %h n=%0d exp 0000 n=1", d, vc);
    end
    checks++;
    if (ec != 1 || ei != vi) begin
      errors++;
      $display("FAIL oor_rd_err got n=%0d at %0d exp 1 at %0d",
               ec, ei, vi);
    end
  endtask

  task automatic test_rd_wr_both;
    word_t d;
    int wc, vc, vi, ec, ei;
    @(posedge clk); #1;
    i_mem_addr = 16'h0004;
    i_mem_wrdata = 16'h5555;
    i_mem_rd = 1'b1;
    i_mem_wr = 1'b1;
    wait_idle("both");
    @(posedge clk); #1;
    i_mem_rd = 1'b0;
    i_mem_wr = 1'b0;
    model_write(16'h0004, 16'h5555);
    observe(d, wc, vc, vi, ec, ei);
    checks++;
    if (vc != 0 || wc != 0) begin
      errors++;
      $display("FAIL both_novalid got v=%0d w=%0d exp 0 0", vc, wc);
    end
    checks++;
    if (ec != 1) begin
      errors++;
      $display("FAIL both_err got %0d exp 1", ec);
    end
    do_read(16'h0004, d, wc, vc, vi, ec, ei);
    checks++;
    if (d !== 16'h5555 || ec != 0) begin
      errors++;
      $display("FAIL both_readback got %h e=%0d exp 5555 e=0", d, ec);
    end
  endtask

  task automatic test_reset_in_wait;
    bit e;
    word_t d;
    int wc, vc, vi, ec, ei;
    do_write(16'h0060, 16'h7E57, e);
    @(posedge clk); #1;
    i_mem_addr = 16'h0060;
    i_mem_rd = 1'b1;
    wait_idle("rst");
    @(posedge clk); #1;
    i_mem_rd = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (o_mem_waitrequest !== 1'b1) begin
      errors++;
      $display("FAIL rst_pending got %b exp 1", o_mem_waitrequest);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (o_mem_waitrequest !== 1'b0) begin
      errors++;
      $display("FAIL rst_idle got %b exp 0", o_mem_waitrequest);
    end
    vc = 0;
    if (o_mem_rddata_valid) vc++;
    repeat (3) begin
      @(negedge clk);
      if (o_mem_rddata_valid) vc++;
    end
    checks++;
    if (vc != 0) begin
      errors++;
      $display("FAIL rst_novalid got %0d exp 0", vc);
    end
    do_read(16'h0060, d, wc, vc, vi, ec, ei);
    checks++;
    if (d !== 16'h7E57 || vc != 1 || vi != L - 1) begin
      errors++;
      $display("FAIL rst_after got %h n=%0d at %0d exp 7e57 1 %0d",
               d, vc, vi, L - 1);
    end
  endtask

  task automatic test_back_to_back;
    bit e;
    word_t d, nv;
    int wc, vc, vi, ec, ei;
    do_write(16'h0040, 16'h0F0F, e);
    nv = 16'($urandom);
    @(posedge clk); #1;
    i_mem_addr = 16'h0040;
    i_mem_wrdata = nv;
    i_mem_wr = 1'b1;
    @(posedge clk); #1;
    i_mem_wr = 1'b0;
    i_mem_rd = 1'b1;
    @(posedge clk); #1;
    i_mem_rd = 1'b0;
    model_write(16'h0040, nv);
    observe(d, wc, vc, vi, ec, ei);
    checks++;
    if (d !== mdl[32] || vc != 1) begin
      errors++;
      $display("FAIL raw_data got %h n=%0d exp %h n=1", d, vc, mdl[32]);
    end
  endtask

  task automatic test_random;
    bit e, exp_e;
    word_t d, wv, exp_d;
    int wc, vc, vi, ec, ei, idx, op, odd, exp_ec;
    logic [15:0] a;
    for (int t = 0; t < 60; t++) begin
      op  = int'($urandom_range(0, 2));
      idx = int'($urandom_range(0, DEPTH + 15));
      odd = (idx < DEPTH) ? int'($urandom_range(0, 1)) : 0;
      a   = 16'(idx * 2 + odd);
      if (op == 0 || (idx < DEPTH && !written[idx])) begin
        wv = 16'($urandom);
        exp_e = (odd == 1) || (idx >= DEPTH);
        do_write(a, wv, e);
        checks++;
        if (e !== exp_e) begin
          errors++;
          $display("FAIL rnd_wr_err a=%h got %b exp %b", a, e, exp_e);
        end
      end else begin
        exp_d  = (idx < DEPTH) ? mdl[idx] : 16'h0000;
        exp_ec = ((odd == 1) || (idx >= DEPTH)) ? 1 : 0;
        do_read(a, d, wc, vc, vi, ec, ei);
        checks++;
        if (d !== exp_d || vc != 1 || ec != exp_ec) begin
          errors++;
          $display("FAIL rnd_rd a=%h got %h v=%0d e=%0d exp %h 1 %0d",
                   a, d, vc, ec, exp_d, exp_ec);
        end
      end
    end
  endtask

  task automatic test_mmio;
    bit e;
    word_t d;
    int wc, vc, vi, ec, ei;
    i_switches = 16'h0C3A;
    do_write(16'hFF00, 16'h00F0, e);
`ifdef MEM_RESP_MMIO_EN
    checks++;
    if (o_leds !== 16'h00F0 || e !== 1'b0) begin
      errors++;
      $display("FAIL mmio_leds got %h e=%b exp 00f0 e=0", o_leds, e);
    end
    do_read(16'hFF02, d, wc, vc, vi, ec, ei);
    checks++;
    if (d !== 16'h0C3A || vc != 1 || ec != 0) begin
      errors++;
      $display("FAIL mmio_sw got %h v=%0d e=%0d exp 0c3a 1 0",
               d, vc, ec);
    end
    do_read(16'hFF00, d, wc, vc, vi, ec, ei);
    checks++;
    if (d !== 16'h00F0 || wc != L) begin
      errors++;
      $display("FAIL mmio_ledrd got %h w=%0d exp 00f0 %0d", d, wc, L);
    end
`else
    checks++;
    if (o_leds !== 16'h0000 || e !== 1'b1) begin
      errors++;
      $display("FAIL nommio_leds got %h e=%b exp 0000 e=1", o_leds, e);
    end
    do_read(16'hFF02, d, wc, vc, vi, ec, ei);
    checks++;
    if (d !== 16'h0000 || vc != 1 || ec != 1) begin
      errors++;
      $display("FAIL nommio_rd got %h v=%0d e=%0d exp 0000 1 1",
               d, vc, ec);
    end
`endif
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) written[i] = 1'b0;
    test_reset();
    test_basic();
    test_misaligned();
    test_out_of_range();
    test_rd_wr_both();
    test_reset_in_wait();
    test_back_to_back();
    test_random();
    test_mmio();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
